// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predict unit and its condition evaluator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bp_pkg;

    // Default widths; the BTB entry fields are sized from these, so the top-level
    // XLEN/TAGW parameters must be left at these values.
    localparam int BP_XLEN = 32;
    localparam int BP_TAGW = 8;

    // RV32I conditional branch funct3 encodings.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Two-bit saturating counter states.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic                is_jump;
        logic [BP_TAGW-1:0]  tag;
        logic [BP_XLEN-1:0]  target;
        logic [1:0]          cnt;
    } btb_entry_t;

    // Saturating counter step: towards ST when taken, towards SNT when not.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != ST) begin
            nxt = cnt + 2'd1;
        end else if (!taken && cnt != SNT) begin
            nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_cond_eval.sv
// Evaluates the RV32I branch condition from funct3 and the ALU compare flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module bp_cond_eval
    import bp_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    output logic       cond_o,
    output logic       illegal_o
);

    // funct3 decode; 010/011 are not branch encodings and resolve not-taken.
    always_comb begin
        cond_o    = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  cond_o = zero_i;
            F3_BNE:  cond_o = ~zero_i;
            F3_BLT:  cond_o = lt_i;
            F3_BGE:  cond_o = ~lt_i;
            F3_BLTU: cond_o = ltu_i;
            F3_BGEU: cond_o = ~ltu_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution in execute plus a direct-mapped BTB with 2-bit counters for fetch.
// Latency: lookup and resolution are combinational; BTB/stat updates land on the next clk edge.
// Backpressure: none; one lookup and one resolution accepted every cycle.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int         XLEN     = BP_XLEN,
    parameter int         ENTRIES  = 64,
    parameter int         TAGW     = BP_TAGW,
    parameter logic [1:0] CNT_INIT = WNT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    output logic [XLEN-1:0] f_pred_target,
    input  logic            e_valid,
    input  logic [XLEN-1:0] e_pc,
    input  logic            e_branch,
    input  logic            e_jump,
    input  logic [2:0]      e_funct3,
    input  logic            e_zero,
    input  logic            e_lt,
    input  logic            e_ltu,
    input  logic [XLEN-1:0] e_target,
    input  logic            e_pred_taken,
    input  logic [XLEN-1:0] e_pred_target,
    output logic            e_taken,
    output logic            e_mispredict,
    output logic [XLEN-1:0] e_redirect_pc,
    output logic            e_illegal,
    output logic [31:0]     stat_ctrl,
    output logic [31:0]     stat_miss
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGL = IDXW + 2;
    localparam int TAGH = IDXW + TAGW + 1;

    btb_entry_t btb_q [ENTRIES];
    logic [31:0] stat_ctrl_q, stat_ctrl_d;
    logic [31:0] stat_miss_q, stat_miss_d;

    // ---------------- fetch-side lookup ----------------
    logic [IDXW-1:0] f_idx;
    logic [TAGW-1:0] f_tag;
    btb_entry_t      f_ent;
    logic            f_hit;

    assign f_idx = f_pc[IDXW+1:2];
    assign f_tag = f_pc[TAGH:TAGL];
    assign f_ent = btb_q[f_idx];
    assign f_hit = f_ent.valid && (f_ent.tag == f_tag);

    // Reads the registered array, so a same-cycle update to this index is not visible yet.
    assign f_pred_taken  = f_hit && (f_ent.is_jump || f_ent.cnt[1]);
    assign f_pred_target = f_pred_taken ? f_ent.target : '0;

    // ---------------- execute-side resolution ----------------
    logic cond;
    logic f3_illegal;

    bp_cond_eval u_cond (
        .funct3_i  (e_funct3),
        .zero_i    (e_zero),
        .lt_i      (e_lt),
        .ltu_i     (e_ltu),
        .cond_o    (cond),
        .illegal_o (f3_illegal)
    );

    logic e_ctrl;
    logic e_upd;

    assign e_ctrl        = e_valid && (e_branch || e_jump);
    assign e_illegal     = e_valid && e_branch && f3_illegal;
    assign e_taken       = e_valid && (e_jump || (e_branch && cond));
    assign e_redirect_pc = e_taken ? e_target : (e_pc + XLEN'(4));
    assign e_mispredict  = e_ctrl && ((e_taken != e_pred_taken) ||
                                      (e_taken && (e_target != e_pred_target)));
    assign e_upd         = e_ctrl && !e_illegal;

    // ---------------- BTB update ----------------
    logic [IDXW-1:0] e_idx;
    logic [TAGW-1:0] e_tag;
    btb_entry_t      e_ent;
    logic            e_hit;
    logic            wr_en;
    btb_entry_t      wr_entry;

    assign e_idx = e_pc[IDXW+1:2];
    assign e_tag = e_pc[TAGH:TAGL];
    assign e_ent = btb_q[e_idx];
    assign e_hit = e_ent.valid && (e_ent.tag == e_tag);

    // Next contents for the execute index: train on a hit, allocate only on a taken miss.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = e_ent;
        if (e_upd) begin
            if (e_hit) begin
                wr_en = 1'b1;
                if (e_jump) begin
                    wr_entry.is_jump = 1'b1;
                    wr_entry.cnt     = ST;
                end else begin
                    wr_entry.cnt = cnt_next(e_ent.cnt, e_taken);
                end
                if (e_taken) begin
                    wr_entry.target = e_target;
                end
            end else if (e_taken) begin
                wr_en            = 1'b1;
                wr_entry.valid   = 1'b1;
                wr_entry.is_jump = e_jump;
                wr_entry.tag     = e_tag;
                wr_entry.target  = e_target;
                wr_entry.cnt     = e_jump ? ST : WT;
            end
        end
    end

    // BTB storage: async clear of every entry, single write port from execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, is_jump: 1'b0, tag: '0, target: '0, cnt: CNT_INIT};
            end
        end else if (wr_en) begin
            btb_q[e_idx] <= wr_entry;
        end
    end

    // ---------------- statistics ----------------
    // Saturating increments; both counters stop at all-ones.
    always_comb begin
        stat_ctrl_d = stat_ctrl_q;
        stat_miss_d = stat_miss_q;
        if (e_upd && stat_ctrl_q != 32'hFFFF_FFFF) begin
            stat_ctrl_d = stat_ctrl_q + 32'd1;
        end
        if (e_mispredict && stat_miss_q != 32'hFFFF_FFFF) begin
            stat_miss_d = stat_miss_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ctrl_q <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_ctrl_q <= stat_ctrl_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_ctrl = stat_ctrl_q;
    assign stat_miss = stat_miss_q;

    // PC bits outside the index/tag fields do not take part in the BTB.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc[1:0], f_pc[XLEN-1:TAGH+1], e_pc[1:0], e_pc[XLEN-1:TAGH+1]};

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic [31:0] f_pred_target;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_branch;
    logic        e_jump;
    logic [2:0]  e_funct3;
    logic        e_zero;
    logic        e_lt;
    logic        e_ltu;
    logic [31:0] e_target;
    logic        e_pred_taken;
    logic [31:0] e_pred_target;
    logic        e_taken;
    logic        e_mispredict;
    logic [31:0] e_redirect_pc;
    logic        e_illegal;
    logic [31:0] stat_ctrl;
    logic [31:0] stat_miss;

    int n_pass  = 0;
    int n_total = 0;

    branch_predict_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .f_pc          (f_pc),
        .f_pred_taken  (f_pred_taken),
        .f_pred_target (f_pred_target),
        .e_valid       (e_valid),
        .e_pc          (e_pc),
        .e_branch      (e_branch),
        .e_jump        (e_jump),
        .e_funct3      (e_funct3),
        .e_zero        (e_zero),
        .e_lt          (e_lt),
        .e_ltu         (e_ltu),
        .e_target      (e_target),
        .e_pred_taken  (e_pred_taken),
        .e_pred_target (e_pred_target),
        .e_taken       (e_taken),
        .e_mispredict  (e_mispredict),
        .e_redirect_pc (e_redirect_pc),
        .e_illegal     (e_illegal),
        .stat_ctrl     (stat_ctrl),
        .stat_miss     (stat_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one execute-stage instruction.
    task automatic set_e(input logic v, input logic br, input logic jp, input logic [2:0] f3,
                         input logic z, input logic lt, input logic ltu, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        e_valid = v; e_branch = br; e_jump = jp; e_funct3 = f3;
        e_zero = z; e_lt = lt; e_ltu = ltu; e_pc = pc; e_target = tgt;
        e_pred_taken = ptk; e_pred_target = ptgt;
    endtask

    task automatic idle_e();
        set_e(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Let one rising edge happen, return on the following falling edge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        f_pc  = 32'h100;
        idle_e();
        #1;
        n_total++; if (f_pred_taken !== 1'b0) $display("FAIL reset_pred_taken: got %0b want 0", f_pred_taken); else n_pass++;
        n_total++; if (f_pred_target !== 32'h0) $display("FAIL reset_pred_target: got %h want 0", f_pred_target); else n_pass++;
        n_total++; if (stat_ctrl !== 32'h0) $display("FAIL reset_stat_ctrl: got %h want 0", stat_ctrl); else n_pass++;
        n_total++; if (stat_miss !== 32'h0) $display("FAIL reset_stat_miss: got %h want 0", stat_miss); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_beq_taken();
        f_pc = 32'h100;
        set_e(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h0);
        #1;
        n_total++; if (e_taken !== 1'b1) $display("FAIL beq_taken: got %0b want 1", e_taken); else n_pass++;
        n_total++; if (e_mispredict !== 1'b1) $display("FAIL beq_mispredict: got %0b want 1", e_mispredict); else n_pass++;
        n_total++; if (e_redirect_pc !== 32'h80) $display("FAIL beq_redirect: got %h want 80", e_redirect_pc); else n_pass++;
        n_total++; if (f_pred_taken !== 1'b0) $display("FAIL beq_no_bypass: got %0b want 0", f_pred_taken); else n_pass++;
        next_cycle();
        idle_e();
        #1;
        n_total++; if (f_pred_taken !== 1'b1) $display("FAIL beq_pred_taken: got %0b want 1", f_pred_taken); else n_pass++;
        n_total++; if (f_pred_target !== 32'h80) $display("FAIL beq_pred_target: got %h want 80", f_pred_target); else n_pass++;
        n_total++; if (stat_ctrl !== 32'd1 || stat_miss !== 32'd1) $display("FAIL beq_stats: got ctrl=%0d miss=%0d want 1/1", stat_ctrl, stat_miss); else n_pass++;
    endtask

    task automatic test_beq_not_taken();
        f_pc = 32'h100;
        // First: fetch predicted taken to 0x80, actually falls through.
        set_e(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
        #1;
        n_total++; if (e_taken !== 1'b0) $display("FAIL nt1_taken: got %0b want 0", e_taken); else n_pass++;
        n_total++; if (e_mispredict !== 1'b1) $display("FAIL nt1_mispredict: got %0b want 1", e_mispredict); else n_pass++;
        n_total++; if (e_redirect_pc !== 32'h104) $display("FAIL nt1_redirect: got %h want 104", e_redirect_pc); else n_pass++;
        next_cycle();
        idle_e();
        #1;
        n_total++; if (f_pred_taken !== 1'b0) $display("FAIL nt1_pred_after: got %0b want 0", f_pred_taken); else n_pass++;
        // Second: predicted not taken, not taken.
        set_e(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h0);
        #1;
        n_total++; if (e_mispredict !== 1'b0) $display("FAIL nt2_mispredict: got %0b want 0", e_mispredict); else n_pass++;
        n_total++; if (e_redirect_pc !== 32'h104) $display("FAIL nt2_redirect: got %h want 104", e_redirect_pc); else n_pass++;
        next_cycle();
        idle_e();
        #1;
        n_total++; if (f_pred_taken !== 1'b0 || f_pred_target !== 32'h0) $display("FAIL nt2_pred_after: got %0b/%h want 0/0", f_pred_taken, f_pred_target); else n_pass++;
        n_total++; if (stat_ctrl !== 32'd3 || stat_miss !== 32'd2) $display("FAIL nt_stats: got ctrl=%0d miss=%0d want 3/2", stat_ctrl, stat_miss); else n_pass++;
    endtask

    task automatic test_cond_sweep();
        // {funct3, zero, lt, ltu, expected taken, expected illegal}
        logic [7:0] vec [14];
        logic [7:0] v;
        vec[0]  = {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[1]  = {3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[2]  = {3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[3]  = {3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[4]  = {3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[5]  = {3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[6]  = {3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[7]  = {3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[8]  = {3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[9]  = {3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[10] = {3'b111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[11] = {3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[12] = {3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vec[13] = {3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 14; i++) begin
            v = vec[i];
            set_e(1'b1, 1'b1, 1'b0, v[7:5], v[4], v[3], v[2],
                  (i >= 12) ? 32'h700 : 32'h604, 32'h40, 1'b0, 32'h0);
            #1;
            n_total++; if (e_taken !== v[1]) $display("FAIL sweep%0d_taken: got %0b want %0b", i, e_taken, v[1]); else n_pass++;
            n_total++; if (e_illegal !== v[0]) $display("FAIL sweep%0d_illegal: got %0b want %0b", i, e_illegal, v[0]); else n_pass++;
            n_total++; if (e_mispredict !== v[1]) $display("FAIL sweep%0d_mispredict: got %0b want %0b", i, e_mispredict, v[1]); else n_pass++;
            next_cycle();
        end
        idle_e();
        f_pc = 32'h700;
        #1;
        n_total++; if (f_pred_taken !== 1'b0) $display("FAIL illegal_no_write: got %0b want 0", f_pred_taken); else n_pass++;
        // 12 legal branches counted, 6 of them taken against a not-taken prediction.
        n_total++; if (stat_ctrl !== 32'd15 || stat_miss !== 32'd8) $display("FAIL sweep_stats: got ctrl=%0d miss=%0d want 15/8", stat_ctrl, stat_miss); else n_pass++;
        // Non-control instruction with a stale taken prediction: nothing resolves.
        set_e(1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 32'h604, 32'h40, 1'b1, 32'h40);
        #1;
        n_total++; if (e_taken !== 1'b0 || e_mispredict !== 1'b0 || e_illegal !== 1'b0) $display("FAIL nonctrl: got t=%0b m=%0b i=%0b want 0/0/0", e_taken, e_mispredict, e_illegal); else n_pass++;
        next_cycle();
        // Fall-through address wraps at the top of the address space.
        set_e(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h40, 1'b0, 32'h0);
        #1;
        n_total++; if (e_redirect_pc !== 32'h0) $display("FAIL pc_wrap: got %h want 0", e_redirect_pc); else n_pass++;
        next_cycle();
        idle_e();
        #1;
        n_total++; if (stat_ctrl !== 32'd15 || stat_miss !== 32'd8) $display("FAIL nonctrl_stats: got ctrl=%0d miss=%0d want 15/8", stat_ctrl, stat_miss); else n_pass++;
    endtask

    task automatic test_jal_alias();
        set_e(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h200, 32'h400, 1'b0, 32'h0);
        #1;
        n_total++; if (e_taken !== 1'b1 || e_mispredict !== 1'b1 || e_redirect_pc !== 32'h400) $display("FAIL jal_resolve: got t=%0b m=%0b pc=%h want 1/1/400", e_taken, e_mispredict, e_redirect_pc); else n_pass++;
        next_cycle();
        idle_e();
        f_pc = 32'h200;
        #1;
        n_total++; if (f_pred_taken !== 1'b1 || f_pred_target !== 32'h400) $display("FAIL jal_pred: got %0b/%h want 1/400", f_pred_taken, f_pred_target); else n_pass++;
        // 0x300 shares the index with 0x200 (64 entries * 4 bytes apart), different tag.
        set_e(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h300, 32'h999, 1'b0, 32'h0);
        #1;
        n_total++; if (e_taken !== 1'b0 || e_mispredict !== 1'b0) $display("FAIL alias_resolve: got t=%0b m=%0b want 0/0", e_taken, e_mispredict); else n_pass++;
        next_cycle();
        idle_e();
        f_pc = 32'h200;
        #1;
        n_total++; if (f_pred_taken !== 1'b1 || f_pred_target !== 32'h400) $display("FAIL alias_jal_kept: got %0b/%h want 1/400", f_pred_taken, f_pred_target); else n_pass++;
        f_pc = 32'h300;
        #1;
        n_total++; if (f_pred_taken !== 1'b0) $display("FAIL alias_no_pred: got %0b want 0", f_pred_taken); else n_pass++;
        // Right direction, wrong target still mispredicts.
        set_e(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h200, 32'h400, 1'b1, 32'h404);
        #1;
        n_total++; if (e_mispredict !== 1'b1) $display("FAIL jal_bad_target: got %0b want 1", e_mispredict); else n_pass++;
        next_cycle();
        idle_e();
        #1;
        n_total++; if (stat_ctrl !== 32'd18 || stat_miss !== 32'd10) $display("FAIL jal_stats: got ctrl=%0d miss=%0d want 18/10", stat_ctrl, stat_miss); else n_pass++;
    endtask

    task automatic test_stat_sat_and_reset();
        force dut.stat_miss_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_miss_q;
        set_e(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h0);
        #1;
        n_total++; if (e_mispredict !== 1'b1) $display("FAIL sat_mispredict: got %0b want 1", e_mispredict); else n_pass++;
        next_cycle();
        idle_e();
        #1;
        n_total++; if (stat_miss !== 32'hFFFF_FFFF) $display("FAIL stat_miss_sat: got %h want ffffffff", stat_miss); else n_pass++;
        n_total++; if (stat_ctrl !== 32'd19) $display("FAIL sat_ctrl: got %0d want 19", stat_ctrl); else n_pass++;
        // Reset arrives while a JAL update is pending.
        f_pc = 32'h100;
        #1;
        n_total++; if (f_pred_taken !== 1'b1 || f_pred_target !== 32'h80) $display("FAIL prereset_pred: got %0b/%h want 1/80", f_pred_taken, f_pred_target); else n_pass++;
        set_e(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h200, 32'h400, 1'b0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        n_total++; if (stat_ctrl !== 32'h0 || stat_miss !== 32'h0) $display("FAIL midreset_stats: got ctrl=%h miss=%h want 0/0", stat_ctrl, stat_miss); else n_pass++;
        n_total++; if (f_pred_taken !== 1'b0 || f_pred_target !== 32'h0) $display("FAIL midreset_pred: got %0b/%h want 0/0", f_pred_taken, f_pred_target); else n_pass++;
        n_total++; if (e_taken !== 1'b1 || e_redirect_pc !== 32'h400) $display("FAIL midreset_comb: got t=%0b pc=%h want 1/400", e_taken, e_redirect_pc); else n_pass++;
        @(negedge clk);
        idle_e();
        rst_n = 1'b1;
        f_pc = 32'h200;
        #1;
        n_total++; if (f_pred_taken !== 1'b0) $display("FAIL postreset_jal_gone: got %0b want 0", f_pred_taken); else n_pass++;
        next_cycle();
        #1;
        n_total++; if (stat_ctrl !== 32'h0 || stat_miss !== 32'h0) $display("FAIL postreset_stats: got ctrl=%h miss=%h want 0/0", stat_ctrl, stat_miss); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_beq_not_taken();
        test_cond_sweep();
        test_jal_alias();
        test_stat_sat_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
